output_ctrl: RTL

- Egress-side counterpart of the router input controller.
- Collects flits from N_VIRT_CHN per-VC sources inside the router and arbitrates among them with wormhole locking.
- Drives a single flit/valid/ready/vc_id link towards the next router or NI.
- One register stage gives one-cycle latency with full throughput under continuous ready.

---
 rtl/output_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/output_ctrl.sv
// Router egress controller: fixed-priority VC arbitration with wormhole locking
// feeding a single registered flit/valid/ready/vc_id output stage.
module output_ctrl #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 2
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0]   vc_flit_i,
    input  logic [N_VIRT_CHN-1:0]              vc_valid_i,
    output logic [N_VIRT_CHN-1:0]              vc_ready_o,
    output logic [FLIT_WIDTH-1:0]              flit_data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [$clog2(N_VIRT_CHN)-1:0]      vc_id_o,
    output logic                               lock_o,
    output logic                               pkt_err_o
);

    localparam int VC_W = $clog2(N_VIRT_CHN);

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [VC_W-1:0]         r_lock_vc;
    logic [VC_W-1:0]         w_lock_vc_nxt;
    logic                    w_err_nxt;
    logic                    w_lock;

    logic                    r_valid;
    logic [FLIT_WIDTH-1:0]   r_flit;
    logic [VC_W-1:0]         r_vc_id;
    logic                    r_pkt_err;

    logic                    w_can_load;
    logic                    w_xfer_in;
    logic [N_VIRT_CHN-1:0]   w_grant;
    logic [N_VIRT_CHN-1:0]   w_vc_ready;
    logic [VC_W-1:0]         w_gidx;
    logic [FLIT_WIDTH-1:0]   w_in_flit;
    logic [1:0]              w_in_type;

    assign w_can_load = ~r_valid | ready_i;

    // Ascending scan lets the highest-index valid VC overwrite lower ones.
    always_comb begin
        w_grant = '0;
        if (r_state == ST_LOCKED) begin
            w_grant[r_lock_vc] = vc_valid_i[r_lock_vc];
        end else begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                if (vc_valid_i[i]) begin
                    w_grant    = '0;
                    w_grant[i] = 1'b1;
                end
            end
        end
    end

    assign w_vc_ready = arst ? (w_grant & {N_VIRT_CHN{w_can_load}}) : '0;
    assign w_xfer_in  = |(vc_valid_i & w_vc_ready);

    always_comb begin
        w_gidx    = '0;
        w_in_flit = '0;
        for (int i = 0; i < N_VIRT_CHN; i++) begin
            if (w_grant[i]) begin
                w_gidx    = VC_W'(i);
                w_in_flit = vc_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    assign w_in_type = w_in_flit[FLIT_WIDTH-1 -: 2];

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_state   <= ST_IDLE;
            r_lock_vc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_vc <= w_lock_vc_nxt;
        end
    end

    // While locked only the locked VC is granted, so any accept is on r_lock_vc.
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_vc_nxt = r_lock_vc;
        w_err_nxt     = 1'b0;
        if (w_xfer_in) begin
            case (r_state)
                ST_IDLE: begin
                    case (w_in_type)
                        T_HEAD: begin
                            w_state_nxt   = ST_LOCKED;
                            w_lock_vc_nxt = w_gidx;
                        end
                        T_HT:    w_state_nxt = ST_IDLE;
                        default: w_err_nxt   = 1'b1;
                    endcase
                end
                ST_LOCKED: begin
                    case (w_in_type)
                        T_TAIL: w_state_nxt = ST_IDLE;
                        T_BODY: w_state_nxt = ST_LOCKED;
                        T_HEAD: w_err_nxt   = 1'b1;
                        default: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_lock = (r_state == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_valid   <= 1'b0;
            r_flit    <= '0;
            r_vc_id   <= '0;
            r_pkt_err <= 1'b0;
        end else begin
            r_pkt_err <= w_err_nxt;
            if (w_xfer_in) begin
                r_valid <= 1'b1;
                r_flit  <= w_in_flit;
                r_vc_id <= w_gidx;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign vc_ready_o  = w_vc_ready;
    assign flit_data_o = r_flit;
    assign valid_o     = r_valid;
    assign vc_id_o     = r_vc_id;
    assign lock_o      = w_lock;
    assign pkt_err_o   = r_pkt_err;

endmodule
